// File: rtl/x2c_bcnt_sfifo_pkg.sv
// Package: x2c_bcnt_sfifo_pkg
// Purpose : Shared constants and types for the x2c byte-count FIFO.
//           - FIFO_STD / FIFO_FWFT : read-mode selectors for the FWFT parameter
//           - DEF_WIDTH / DEF_PTR  : default data width and address width
//           - pf_state_t           : state encoding of the FWFT prefetch controller
package x2c_bcnt_sfifo_pkg;

  localparam int FIFO_STD  = 0;
  localparam int FIFO_FWFT = 1;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_PTR   = 8;

  // IDLE : output register holds no word
  // FETCH: RAM read issued, word lands in the output register on the next edge
  // VALID: output register holds the head-of-queue word
  typedef enum logic [1:0] {
    PF_IDLE  = 2'd0,
    PF_FETCH = 2'd1,
    PF_VALID = 2'd2
  } pf_state_t;

endpackage

// File: rtl/x2c_bcnt_sfifo_sdp_ram.sv
// Module : x2c_bcnt_sfifo_sdp_ram
// Purpose: Simple dual-port RAM, WIDTH x 2**PTR, one write port and one
//          registered read port. No reset: contents and the read register
//          power up undefined and are only qualified by the FIFO controller.
// Ports  : clk      - clock, rising edge
//          we       - write enable
//          wr_addr  - write address
//          wr_data  - write data
//          re       - read enable (read register loads only when set)
//          rd_addr  - read address
//          rd_data  - registered read data, held while re is low
module x2c_bcnt_sfifo_sdp_ram #(
  parameter int WIDTH = 32,
  parameter int PTR   = 8
) (
  input  logic             clk,
  input  logic             we,
  input  logic [PTR-1:0]   wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             re,
  input  logic [PTR-1:0]   rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [2**PTR];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (re) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/x2c_bcnt_sfifo.sv
// Module : x2c_bcnt_sfifo
// Purpose: Parametrised single-clock byte-count FIFO with almost-full /
//          almost-empty thresholds, optional first-word-fall-through read
//          mode, full-range fill count and sticky overflow/underflow flags.
// Ports  : clk          - clock, rising edge
//          aclr         - asynchronous reset, active-high
//          wrreq/data   - write request and write word
//          full         - usedw == DEPTH
//          almost_full  - usedw >= AFULL_TH
//          rdreq        - read request (FWFT: pop of the word shown on q)
//          q            - read word
//          empty        - no word available to read
//          almost_empty - usedw <= AEMPTY_TH
//          usedw        - words held, 0..DEPTH
//          err_clr      - synchronous clear of ovf/udf
//          ovf / udf    - sticky: write while full / read while empty
// Note   : DEPTH must equal 2**PTR; AFULL_TH and AEMPTY_TH must lie in 0..DEPTH.
module x2c_bcnt_sfifo
  import x2c_bcnt_sfifo_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int PTR       = DEF_PTR,
  parameter int DEPTH     = 2**PTR,
  parameter int AFULL_TH  = DEPTH - 8,
  parameter int AEMPTY_TH = 4,
  parameter int FWFT      = FIFO_STD
) (
  input  logic             clk,
  input  logic             aclr,
  input  logic             wrreq,
  input  logic [WIDTH-1:0] data,
  output logic             full,
  output logic             almost_full,
  input  logic             rdreq,
  output logic [WIDTH-1:0] q,
  output logic             empty,
  output logic             almost_empty,
  output logic [PTR:0]     usedw,
  input  logic             err_clr,
  output logic             ovf,
  output logic             udf
);

  localparam bit             IS_FWFT  = (FWFT == FIFO_FWFT);
  localparam logic [PTR:0]   CNT_ONE  = (PTR+1)'(1);
  localparam logic [PTR:0]   CNT_FULL = (PTR+1)'(DEPTH);
  localparam logic [PTR:0]   AF_LVL   = (PTR+1)'(AFULL_TH);
  localparam logic [PTR:0]   AE_LVL   = (PTR+1)'(AEMPTY_TH);
  localparam logic [PTR-1:0] PTR_ONE  = PTR'(1);

  logic [PTR-1:0]   wr_ptr;
  logic [PTR-1:0]   rd_ptr;
  logic [PTR:0]     usedw_r;
  logic [PTR:0]     usedw_nxt;
  logic [PTR:0]     ram_cnt;
  logic [PTR:0]     ram_cnt_nxt;
  logic             full_r;
  logic             af_r;
  logic             ae_r;
  logic             empty_r;
  logic             empty_nxt;
  logic             ovf_r;
  logic             udf_r;
  logic             wr_acc;
  logic             rd_acc;
  logic             ram_rd;
  logic             vld_p0;
  logic [WIDTH-1:0] rd_data_p0;
  logic [WIDTH-1:0] q_p1;
  pf_state_t        pf_state;
  pf_state_t        pf_nxt;

  // Requests are qualified against registered flags only, so a write
  // while full is rejected even if a read frees a slot in the same cycle.
  assign wr_acc = wrreq & ~full_r;
  assign rd_acc = rdreq & ~empty_r;

  // In standard mode every accepted read issues a RAM read. In FWFT mode the
  // prefetch controller decides when to move the RAM head into q.
  always_comb begin
    pf_nxt = pf_state;
    ram_rd = 1'b0;
    if (IS_FWFT) begin
      case (pf_state)
        PF_IDLE: begin
          if (ram_cnt != '0) begin
            ram_rd = 1'b1;
            pf_nxt = PF_FETCH;
          end
        end
        PF_FETCH: begin
          pf_nxt = PF_VALID;
        end
        PF_VALID: begin
          if (rd_acc) begin
            if (ram_cnt != '0) begin
              ram_rd = 1'b1;
              pf_nxt = PF_FETCH;
            end else begin
              pf_nxt = PF_IDLE;
            end
          end
        end
        default: begin
          pf_nxt = PF_IDLE;
        end
      endcase
    end else begin
      ram_rd = rd_acc;
    end
  end

  // usedw counts every word owned by the FIFO, including the one parked in
  // the FWFT output register; ram_cnt counts only words not yet read from RAM.
  always_comb begin
    usedw_nxt = usedw_r;
    case ({wr_acc, rd_acc})
      2'b10:   usedw_nxt = usedw_r + CNT_ONE;
      2'b01:   usedw_nxt = usedw_r - CNT_ONE;
      default: usedw_nxt = usedw_r;
    endcase

    ram_cnt_nxt = ram_cnt;
    case ({wr_acc, ram_rd})
      2'b10:   ram_cnt_nxt = ram_cnt + CNT_ONE;
      2'b01:   ram_cnt_nxt = ram_cnt - CNT_ONE;
      default: ram_cnt_nxt = ram_cnt;
    endcase

    // FWFT empty follows the output register, so it may trail usedw
    // by the fetch latency after a write into an empty FIFO.
    if (IS_FWFT) begin
      empty_nxt = (pf_nxt != PF_VALID);
    end else begin
      empty_nxt = (usedw_nxt == '0);
    end
  end

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      usedw_r  <= '0;
      ram_cnt  <= '0;
      full_r   <= 1'b0;
      af_r     <= 1'b0;
      ae_r     <= 1'b1;
      empty_r  <= 1'b1;
      pf_state <= PF_IDLE;
      vld_p0   <= 1'b0;
      ovf_r    <= 1'b0;
      udf_r    <= 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (ram_rd) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      usedw_r  <= usedw_nxt;
      ram_cnt  <= ram_cnt_nxt;
      full_r   <= (usedw_nxt == CNT_FULL);
      af_r     <= (usedw_nxt >= AF_LVL);
      ae_r     <= (usedw_nxt <= AE_LVL);
      empty_r  <= empty_nxt;
      pf_state <= pf_nxt;
      vld_p0   <= ram_rd;

      // A new violation wins over a clear in the same cycle.
      if (wrreq && full_r) begin
        ovf_r <= 1'b1;
      end else if (err_clr) begin
        ovf_r <= 1'b0;
      end
      if (rdreq && empty_r) begin
        udf_r <= 1'b1;
      end else if (err_clr) begin
        udf_r <= 1'b0;
      end
    end
  end

  // ---- stage p0: RAM read register ----
  x2c_bcnt_sfifo_sdp_ram #(
    .WIDTH (WIDTH),
    .PTR   (PTR)
  ) u_ram (
    .clk     (clk),
    .we      (wr_acc),
    .wr_addr (wr_ptr),
    .wr_data (data),
    .re      (ram_rd),
    .rd_addr (rd_ptr),
    .rd_data (rd_data_p0)
  );

  // ---- stage p1: output register, resettable and held between reads ----
  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      q_p1 <= '0;
    end else if (vld_p0) begin
      q_p1 <= rd_data_p0;
    end
  end

  assign q            = q_p1;
  assign usedw        = usedw_r;
  assign full         = full_r;
  assign almost_full  = af_r;
  assign empty        = empty_r;
  assign almost_empty = ae_r;
  assign ovf          = ovf_r;
  assign udf          = udf_r;

endmodule

// File: tb/tb_x2c_bcnt_sfifo.sv
// Testbench for x2c_bcnt_sfifo: one standard-mode and one FWFT instance,
// each compared against a queue-based model of the FIFO contents.
module tb_x2c_bcnt_sfifo;

  localparam int DEPTH = 256;
  localparam int AF_TH = DEPTH - 8;
  localparam int AE_TH = 4;

  logic        clk = 1'b0;
  logic        aclr;

  // standard-mode instance
  logic        wrreq, rdreq, err_clr;
  logic [31:0] data;
  logic        full, almost_full, empty, almost_empty, ovf, udf;
  logic [31:0] q;
  logic [8:0]  usedw;

  // FWFT instance
  logic        f_wrreq, f_rdreq, f_err_clr;
  logic [31:0] f_data;
  logic        f_full, f_almost_full, f_empty, f_almost_empty, f_ovf, f_udf;
  logic [31:0] f_q;
  logic [8:0]  f_usedw;

  int total = 0;
  int bad   = 0;

  // standard-mode model
  logic [31:0] m_q[$];
  logic [31:0] m_qout;
  logic [31:0] m_pend_data;
  bit          m_pend, m_ovf, m_udf;

  // FWFT model
  logic [31:0] f_mq[$];
  bit          f_movf, f_mudf;

  always #5 clk = ~clk;

  x2c_bcnt_sfifo #(.WIDTH(32), .PTR(8), .FWFT(0)) u_std (
    .clk(clk), .aclr(aclr), .wrreq(wrreq), .data(data), .full(full),
    .almost_full(almost_full), .rdreq(rdreq), .q(q), .empty(empty),
    .almost_empty(almost_empty), .usedw(usedw), .err_clr(err_clr),
    .ovf(ovf), .udf(udf)
  );

  x2c_bcnt_sfifo #(.WIDTH(32), .PTR(8), .FWFT(1)) u_fwft (
    .clk(clk), .aclr(aclr), .wrreq(f_wrreq), .data(f_data), .full(f_full),
    .almost_full(f_almost_full), .rdreq(f_rdreq), .q(f_q), .empty(f_empty),
    .almost_empty(f_almost_empty), .usedw(f_usedw), .err_clr(f_err_clr),
    .ovf(f_ovf), .udf(f_udf)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_std(input string tag);
    int n;
    n = m_q.size();
    chk({tag, "_usedw"}, usedw, n);
    chk({tag, "_full"}, full, n == DEPTH);
    chk({tag, "_afull"}, almost_full, n >= AF_TH);
    chk({tag, "_empty"}, empty, n == 0);
    chk({tag, "_aempty"}, almost_empty, n <= AE_TH);
    chk({tag, "_q"}, q, m_qout);
    chk({tag, "_ovf"}, ovf, m_ovf);
    chk({tag, "_udf"}, udf, m_udf);
  endtask

  // One clock of the standard instance: model the edge, apply it, compare.
  task automatic cyc(input bit w, input bit r, input logic [31:0] d, input bit c, input string tag);
    bit full_m, empty_m, wacc, racc;
    full_m  = (m_q.size() == DEPTH);
    empty_m = (m_q.size() == 0);
    wacc    = w && !full_m;
    racc    = r && !empty_m;
    if (m_pend) m_qout = m_pend_data;
    m_pend = racc;
    if (racc) m_pend_data = m_q.pop_front();
    if (wacc) m_q.push_back(d);
    if (w && full_m) m_ovf = 1'b1; else if (c) m_ovf = 1'b0;
    if (r && empty_m) m_udf = 1'b1; else if (c) m_udf = 1'b0;
    wrreq = w; rdreq = r; data = d; err_clr = c;
    @(posedge clk); #1;
    wrreq = 1'b0; rdreq = 1'b0; err_clr = 1'b0;
    check_std(tag);
  endtask

  // One clock of the FWFT instance. A pop is taken when the bench raises
  // rdreq while the instance shows a word; that word must be the queue head.
  task automatic fcyc(input bit w, input bit r, input logic [31:0] d, input bit c, input string tag);
    bit full_m, wacc, racc;
    int n;
    full_m = (f_mq.size() == DEPTH);
    wacc   = w && !full_m;
    racc   = r && !f_empty;
    if (racc) begin
      chk({tag, "_avail"}, f_mq.size() > 0, 1);
      if (f_mq.size() > 0) begin
        chk({tag, "_q"}, f_q, f_mq[0]);
        void'(f_mq.pop_front());
      end
    end
    if (wacc) f_mq.push_back(d);
    if (w && full_m) f_movf = 1'b1; else if (c) f_movf = 1'b0;
    if (r && f_empty) f_mudf = 1'b1; else if (c) f_mudf = 1'b0;
    f_wrreq = w; f_rdreq = r; f_data = d; f_err_clr = c;
    @(posedge clk); #1;
    f_wrreq = 1'b0; f_rdreq = 1'b0; f_err_clr = 1'b0;
    n = f_mq.size();
    chk({tag, "_usedw"}, f_usedw, n);
    chk({tag, "_full"}, f_full, n == DEPTH);
    chk({tag, "_afull"}, f_almost_full, n >= AF_TH);
    chk({tag, "_aempty"}, f_almost_empty, n <= AE_TH);
    chk({tag, "_ovf"}, f_ovf, f_movf);
    chk({tag, "_udf"}, f_udf, f_mudf);
    if (n == 0) chk({tag, "_empty"}, f_empty, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    aclr = 1'b1;
    wrreq = 1'b0; rdreq = 1'b0; err_clr = 1'b0; data = '0;
    f_wrreq = 1'b0; f_rdreq = 1'b0; f_err_clr = 1'b0; f_data = '0;
    m_qout = '0; m_pend_data = '0; m_pend = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;
    f_movf = 1'b0; f_mudf = 1'b0;
    repeat (2) @(posedge clk);
    #1 aclr = 1'b0;

    // reset state of both instances
    check_std("reset");
    chk("f_reset_empty", f_empty, 1);
    chk("f_reset_usedw", f_usedw, 0);
    chk("f_reset_q", f_q, 0);
    chk("f_reset_aempty", f_almost_empty, 1);
    chk("f_reset_afull", f_almost_full, 0);

    // fill 0..255, overflow attempt, drain in order
    for (int i = 0; i < DEPTH; i++) cyc(1'b1, 1'b0, 32'(i), 1'b0, "fill");
    chk("fill_usedw", usedw, 256);
    chk("fill_full", full, 1);
    cyc(1'b1, 1'b0, 32'hDEAD_BEEF, 1'b0, "ovf_wr");
    chk("ovf_set", ovf, 1);
    chk("ovf_usedw", usedw, 256);
    for (int i = 0; i < DEPTH; i++) cyc(1'b0, 1'b1, '0, 1'b0, "drain");
    cyc(1'b0, 1'b0, '0, 1'b0, "drain_tail");
    chk("drain_last_q", q, 255);
    chk("drain_empty", empty, 1);
    cyc(1'b0, 1'b0, '0, 1'b1, "ovf_clr");

    // underflow and clear
    cyc(1'b0, 1'b1, '0, 1'b0, "udf_rd");
    chk("udf_set", udf, 1);
    chk("udf_usedw", usedw, 0);
    cyc(1'b0, 1'b1, '0, 1'b1, "udf_set_wins");
    chk("udf_set_wins", udf, 1);
    cyc(1'b0, 1'b0, '0, 1'b1, "udf_clr");
    chk("udf_cleared", udf, 0);

    // prior transfers to move pointers around, then steady state at 10
    for (int i = 0; i < 400; i++)
      cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, 1'b0, "prior");
    while (m_q.size() < 10) cyc(1'b1, 1'b0, $urandom, 1'b0, "to10_w");
    while (m_q.size() > 10) cyc(1'b0, 1'b1, '0, 1'b0, "to10_r");
    for (int i = 0; i < 50; i++) cyc(1'b1, 1'b1, $urandom, 1'b0, "simul");
    chk("simul_usedw", usedw, 10);

    // full with concurrent read and write
    while (m_q.size() < DEPTH) cyc(1'b1, 1'b0, $urandom, 1'b1, "tofull");
    cyc(1'b1, 1'b1, $urandom, 1'b0, "full_rw");
    chk("full_rw_usedw", usedw, 255);
    chk("full_rw_ovf", ovf, 1);

    // asynchronous reset while a read is in flight
    cyc(1'b1, 1'b1, $urandom, 1'b0, "pre_rst");
    @(posedge clk);
    #2 aclr = 1'b1;
    #1;
    chk("arst_empty", empty, 1);
    chk("arst_usedw", usedw, 0);
    chk("arst_q", q, 0);
    chk("arst_ovf", ovf, 0);
    chk("arst_udf", udf, 0);
    chk("arst_full", full, 0);
    m_q.delete(); m_pend = 1'b0; m_qout = '0; m_ovf = 1'b0; m_udf = 1'b0;
    @(posedge clk);
    #1 aclr = 1'b0;
    check_std("post_rst");

    // randomized traffic, write-heavy then read-heavy
    for (int i = 0; i < 700; i++)
      cyc(($urandom_range(0, 3) != 0), ($urandom_range(0, 3) == 0), $urandom,
          ($urandom_range(0, 15) == 0), "rnd_wh");
    for (int i = 0; i < 700; i++)
      cyc(($urandom_range(0, 3) == 0), ($urandom_range(0, 3) != 0), $urandom,
          ($urandom_range(0, 15) == 0), "rnd_rh");

    // FWFT: single word latency and pop
    fcyc(1'b1, 1'b0, 32'hA5A5_A5A5, 1'b0, "t6_wr");
    chk("t6_empty_n", f_empty, 1);
    fcyc(1'b0, 1'b0, '0, 1'b0, "t6_n1");
    chk("t6_empty_n1", f_empty, 1);
    fcyc(1'b0, 1'b0, '0, 1'b0, "t6_n2");
    chk("t6_empty_n2", f_empty, 0);
    chk("t6_q_n2", f_q, 32'hA5A5_A5A5);
    fcyc(1'b0, 1'b1, '0, 1'b0, "t6_pop");
    chk("t6_empty_pop", f_empty, 1);
    chk("t6_usedw_pop", f_usedw, 0);

    // FWFT randomized traffic and bounded drain
    for (int i = 0; i < 600; i++)
      fcyc(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), $urandom,
           ($urandom_range(0, 15) == 0), "f_rnd_w");
    for (int i = 0; i < 600; i++)
      fcyc(($urandom_range(0, 2) == 0), ($urandom_range(0, 3) != 0), $urandom,
           ($urandom_range(0, 15) == 0), "f_rnd_r");
    guard = 0;
    while (f_mq.size() > 0 && guard < 3 * DEPTH + 16) begin
      fcyc(1'b0, !f_empty, '0, 1'b0, "f_drain");
      guard++;
    end
    chk("f_drain_bound", f_mq.size(), 0);
    fcyc(1'b0, 1'b0, '0, 1'b0, "f_idle");
    chk("f_final_empty", f_empty, 1);
    chk("f_final_usedw", f_usedw, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
